gate_bist_controller: RTL and testbench
=======================================

# gate_bist_controller

- Built-in self-test driver for the combinational gate-model netlists in the gate library.
- Applies a pseudo-random pattern stream from an LFSR to the netlist inputs, one pattern per test cycle.
- Compacts the netlist outputs into a MISR signature and compares the final signature against a golden value.
- Sits between the simulator control logic (start/done handshake) and one gate-model instance (input/output buses).

## Interface
- `IN_W`, 19: pattern width; drives netlist inputs N1..N19 (bit 0 = N1).
- `OUT_W`, 10: response width; netlist outputs in instance port order (bit 0 = first listed output).
- `PATTERNS`, 1024: patterns per run, ≥1; counter width = clog2(PATTERNS)+1.
- `SEED`, 19'h00001: LFSR start value, IN_W bits; a zero value is replaced by 1.
- `POLY_IN`, 19'h00027: LFSR feedback mask, x^19+x^5+x^2+x+1.
- `POLY_OUT`, 10'h009: MISR feedback mask, x^10+x^3+1.

Ports:
- `clk`  in  1  sole clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  run request, sampled only in IDLE.
- `golden`  in  OUT_W  expected signature, sampled on the DONE cycle.
- `resp_in`  in  OUT_W  netlist outputs.
- `pattern_out`  out  IN_W  netlist inputs.
- `busy`  out  1  run in progress.
- `done`  out  1  one-cycle end-of-run pulse.
- `pass`  out  1  signature == golden; valid while `done`=1, held afterwards.
- `signature`  out  OUT_W  MISR contents.

## Operation
- Reset values: state IDLE; `pattern_out`=0; `busy`=0; `done`=0; `pass`=0; `signature`=0; LFSR=SEED; count=0.
- LFSR step: next = {lfsr[IN_W-2:0],1'b0} ^ (lfsr[IN_W-1] ? POLY_IN : 0).
- MISR step: next = ({misr[OUT_W-2:0],1'b0} ^ (misr[OUT_W-1] ? POLY_OUT : 0)) ^ resp_in.
- `pattern_out` = lfsr while `busy`=1, otherwise 0.
- IDLE → RUN on `start`=1. Loads LFSR=SEED (or 1 if SEED==0), clears MISR and count.
- RUN, each capture edge: MISR steps with `resp_in`, LFSR steps, count increments.
- RUN → DONE on the capture edge where count==PATTERNS-1.
- DONE: `done`=1 and `pass` is registered for exactly one cycle, then IDLE.
- `signature` and `pass` hold until the next `start` is accepted.
- `start` while RUN/DONE is ignored. `start` held high restarts on the first IDLE cycle after DONE.
- `rst` during RUN aborts on that edge: all outputs return to reset values and no `done` pulse is issued.
- No X propagation: `resp_in` is sampled only at capture edges.

## Timing
- Edge E0 samples `start`. After E0, `busy`=1 and `pattern_out`=SEED.
- Without settle, edge Ek (k=1..PATTERNS) captures the response to pattern k-1.
- `done` is high in the cycle after E_PATTERNS, with `busy`=0.
- Total latency from the `start` edge to `done` = PATTERNS+1 cycles.
- Throughput: 1 pattern/cycle without settle, 1 pattern/2 cycles with settle.

## Configuration
- Macro `GATE_BIST_SETTLE_EN`.
- Defined: RUN splits into SETTLE and CAPTURE.
  - SETTLE holds the pattern for one cycle with no capture.
  - CAPTURE steps MISR, LFSR and count.
  - Start-to-`done` latency becomes 2·PATTERNS+1.
  - `rst` in either sub-state aborts as above.
- Undefined: single RUN state, one capture per cycle.

## Test plan
- PATTERNS=4, SEED=1, `resp_in`=0 → `pattern_out` 0x00001, 0x00002, 0x00004, 0x00008 on E0..E3 outputs; `done` after E4; `signature`=0x000; `pass`=1 with `golden`=0.
- PATTERNS=4, `resp_in`=10'h001 held → MISR 0x001, 0x003, 0x007, 0x00F; `golden`=0x00F gives `pass`=1; `golden`=0x00E gives `pass`=0.
- SEED=19'h40000, PATTERNS=2 → second pattern 0x00027 (wrap with feedback). SEED=0 → first pattern 0x00001.
- `rst` asserted at E2 of a 4-pattern run → next cycle `busy`=0, `pattern_out`=0, `signature`=0, no `done`. A following `start` produces the full sequence again.
- `start` pulsed during RUN → ignored, `done` after exactly PATTERNS+1 cycles. `start` held high → back-to-back runs with one IDLE cycle between `done` pulses.
- With `GATE_BIST_SETTLE_EN`, PATTERNS=4, `resp_in`=10'h001 → each pattern visible for 2 cycles, `done` after 9 cycles, `signature`=0x00F.

Source files
------------

// File: rtl/gate_bist_controller.sv
// rtl/gate_bist_controller.sv - LFSR/MISR built-in self-test driver for gate-model netlists
//
// Applies PATTERNS pseudo-random patterns from an IN_W-bit LFSR to a
// combinational netlist, compacts its responses into an OUT_W-bit MISR and
// compares the final signature against golden.
//
// Optional feature: define GATE_BIST_SETTLE_EN to give every pattern one
// settle cycle before its capture cycle (1 pattern every 2 cycles).
//
// Ports:
//   clk          sole clock, rising edge
//   rst          synchronous active-high reset, aborts a run in progress
//   start        run request, sampled only in IDLE
//   golden       expected signature, sampled on the done cycle
//   resp_in      netlist outputs
//   pattern_out  netlist inputs (LFSR while busy, else 0)
//   busy         run in progress
//   done         one-cycle end-of-run pulse
//   pass         signature == golden; valid with done, held until next start
//   signature    MISR contents
module gate_bist_controller #(
    parameter int               IN_W     = 19,
    parameter int               OUT_W    = 10,
    parameter int               PATTERNS = 1024,
    parameter logic [IN_W-1:0]  SEED     = 19'h00001,
    parameter logic [IN_W-1:0]  POLY_IN  = 19'h00027,
    parameter logic [OUT_W-1:0] POLY_OUT = 10'h009
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OUT_W-1:0] golden,
    input  logic [OUT_W-1:0] resp_in,
    output logic [IN_W-1:0]  pattern_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [OUT_W-1:0] signature
);

    localparam int CNT_W = $clog2(PATTERNS) + 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(PATTERNS - 1);
    // An all-zero LFSR would lock up, so a zero seed is promoted to 1.
    localparam logic [IN_W-1:0] SEED_EFF = (SEED == '0) ? IN_W'(1) : SEED;

`ifdef GATE_BIST_SETTLE_EN
    typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_RUN, S_DONE} state_t;
    localparam state_t RUN_ENTRY = S_SETTLE;
`else
    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
    localparam state_t RUN_ENTRY = S_RUN;
`endif

    state_t           state_q, state_d;
    logic [IN_W-1:0]  lfsr_q;
    logic [OUT_W-1:0] misr_q;
    logic [CNT_W-1:0] count_q;
    logic             pass_q;
    logic             load;
    logic             capture;
    logic [IN_W-1:0]  lfsr_step;
    logic [OUT_W-1:0] misr_step;
    logic             match;

    assign lfsr_step = {lfsr_q[IN_W-2:0], 1'b0} ^ (lfsr_q[IN_W-1] ? POLY_IN : '0);
    assign misr_step = ({misr_q[OUT_W-2:0], 1'b0} ^ (misr_q[OUT_W-1] ? POLY_OUT : '0)) ^ resp_in;
    assign match     = (misr_q == golden);

    always_comb begin
        state_d = state_q;
        load    = 1'b0;
        capture = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = RUN_ENTRY;
                    load    = 1'b1;
                end
            end
`ifdef GATE_BIST_SETTLE_EN
            S_SETTLE: state_d = S_RUN;
`endif
            S_RUN: begin
                capture = 1'b1;
                state_d = (count_q == LAST) ? S_DONE : RUN_ENTRY;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            lfsr_q  <= SEED_EFF;
            misr_q  <= '0;
            count_q <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            if (load) begin
                lfsr_q  <= SEED_EFF;
                misr_q  <= '0;
                count_q <= '0;
                pass_q  <= 1'b0;
            end else if (capture) begin
                lfsr_q  <= lfsr_step;
                misr_q  <= misr_step;
                count_q <= count_q + 1'b1;
            end
            // Golden is only looked at during the done cycle; the verdict
            // is then frozen so pass stays stable after the pulse.
            if (state_q == S_DONE) begin
                pass_q <= match;
            end
        end
    end

`ifdef GATE_BIST_SETTLE_EN
    assign busy = (state_q == S_RUN) || (state_q == S_SETTLE);
`else
    assign busy = (state_q == S_RUN);
`endif
    assign done        = (state_q == S_DONE);
    assign pass        = done ? match : pass_q;
    assign pattern_out = busy ? lfsr_q : '0;
    assign signature   = misr_q;

endmodule

// File: tb/tb_gate_bist_controller.sv
// tb/tb_gate_bist_controller.sv - directed self-checking bench for gate_bist_controller
`timescale 1ns/1ps
module tb_gate_bist_controller;

`ifdef GATE_BIST_SETTLE_EN
    localparam int STEP = 2;
`else
    localparam int STEP = 1;
`endif
    localparam int PA = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic        start_a, start_b, start_c;
    logic [9:0]  golden, resp_in;
    logic [18:0] pat_a, pat_b, pat_c;
    logic        busy_a, busy_b, busy_c;
    logic        done_a, done_b, done_c;
    logic        pass_a, pass_b, pass_c;
    logic [9:0]  sig_a, sig_b, sig_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    gate_bist_controller #(.PATTERNS(PA), .SEED(19'h00001)) dut_a (
        .clk(clk), .rst(rst), .start(start_a), .golden(golden), .resp_in(resp_in),
        .pattern_out(pat_a), .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a));

    gate_bist_controller #(.PATTERNS(2), .SEED(19'h40000)) dut_b (
        .clk(clk), .rst(rst), .start(start_b), .golden(golden), .resp_in(resp_in),
        .pattern_out(pat_b), .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b));

    gate_bist_controller #(.PATTERNS(PA), .SEED(19'h00000)) dut_c (
        .clk(clk), .rst(rst), .start(start_c), .golden(golden), .resp_in(resp_in),
        .pattern_out(pat_c), .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full run on dut_a; resp is either 0 or 10'h001 so the MISR
    // trajectory is hand-known: 0 throughout, or 0,1,3,7,F.
    task automatic run_a(input logic [9:0] resp, input logic [9:0] gold, input logic exp_pass);
        logic [9:0] exp_sig;
        resp_in = resp;
        golden  = gold;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        for (int k = 0; k < PA; k++) begin
            exp_sig = (resp == 10'h001) ? 10'((1 << k) - 1) : 10'h000;
            for (int s = 0; s < STEP; s++) begin
                check("run_busy", 32'(busy_a), 32'd1);
                check("run_pattern", 32'(pat_a), 32'(1 << k));
                check("run_sig", 32'(sig_a), 32'(exp_sig));
                check("run_done", 32'(done_a), 32'd0);
                tick();
            end
        end
        exp_sig = (resp == 10'h001) ? 10'h00F : 10'h000;
        check("end_done", 32'(done_a), 32'd1);
        check("end_busy", 32'(busy_a), 32'd0);
        check("end_pattern", 32'(pat_a), 32'd0);
        check("end_sig", 32'(sig_a), 32'(exp_sig));
        check("end_pass", 32'(pass_a), 32'(exp_pass));
        tick();
        check("after_done", 32'(done_a), 32'd0);
        check("held_pass", 32'(pass_a), 32'(exp_pass));
        check("held_sig", 32'(sig_a), 32'(exp_sig));
    endtask

    initial begin
        int n;
        int pulses;
        rst = 1'b1; start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
        golden = 10'h000; resp_in = 10'h000;
        tick(); tick();
        rst = 1'b0;
        check("rst_busy", 32'(busy_a), 32'd0);
        check("rst_pattern", 32'(pat_a), 32'd0);
        check("rst_done", 32'(done_a), 32'd0);
        check("rst_pass", 32'(pass_a), 32'd0);
        check("rst_sig", 32'(sig_a), 32'd0);

        // zero response, golden 0
        run_a(10'h000, 10'h000, 1'b1);
        // constant response, matching and non-matching golden
        run_a(10'h001, 10'h00F, 1'b1);
        run_a(10'h001, 10'h00E, 1'b0);

        // LFSR wrap with feedback and zero-seed promotion
        start_b = 1'b1; start_c = 1'b1;
        tick();
        start_b = 1'b0; start_c = 1'b0;
        check("wrap_first", 32'(pat_b), 32'h40000);
        check("zero_seed", 32'(pat_c), 32'h00001);
        for (int s = 0; s < STEP; s++) tick();
        check("wrap_second", 32'(pat_b), 32'h00027);

        // reset during a run
        resp_in = 10'h001;
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        tick();
        for (int s = 1; s < STEP; s++) tick();
        check("pre_abort_sig", 32'(sig_a), 32'h001);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_busy", 32'(busy_a), 32'd0);
        check("abort_pattern", 32'(pat_a), 32'd0);
        check("abort_sig", 32'(sig_a), 32'd0);
        check("abort_done", 32'(done_a), 32'd0);
        pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (done_a) pulses++;
            tick();
        end
        check("abort_no_done", 32'(pulses), 32'd0);
        run_a(10'h001, 10'h00F, 1'b1);

        // start pulsed while running is ignored
        start_a = 1'b1;
        tick();
        start_a = 1'b0;
        n = 0;
        while (!done_a && n < 50) begin
            if (n == 1) start_a = 1'b1;
            if (n == 2) start_a = 1'b0;
            tick();
            n++;
        end
        check("ignored_start_latency", 32'(n), 32'(PA * STEP));
        tick();
        check("ignored_start_idle", 32'(busy_a), 32'd0);

        // start held high: back-to-back runs with one idle cycle between
        start_a = 1'b1;
        n = 0;
        while (!done_a && n < 50) begin
            tick();
            n++;
        end
        check("held_first_latency", 32'(n), 32'(PA * STEP + 1));
        tick();
        check("held_idle_busy", 32'(busy_a), 32'd0);
        check("held_idle_done", 32'(done_a), 32'd0);
        n = 1;
        while (!done_a && n < 50) begin
            tick();
            n++;
        end
        check("held_gap", 32'(n), 32'(PA * STEP + 2));
        start_a = 1'b0;
        tick();
        tick();
        check("held_release_idle", 32'(busy_a), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
